// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and default constants for the button event
//               decoder and the debouncer instantiation wrapper.
//               - btn_state_t : decoder state encoding
//               - DEF_*       : default timing parameters
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    IDLE      = 2'd1,
    PRESSED   = 2'd2,
    LONG_HELD = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_CNT_W         = 24;
  localparam int unsigned DEF_LONG_CYCLES   = 1_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 250_000;

endpackage
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer
// Description : Loadable, saturating up-counter with synchronous clear and a
//               terminal-count compare.
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   zero the count (highest priority)
//   load       in   load load_value
//   load_value in   value loaded when load is high
//   inc        in   count up by one (stops at all-ones)
//   tc_value   in   terminal count compared against the current count
//   at_tc      out  current count equals tc_value
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer
  import button_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             inc,
  input  logic [CNT_W-1:0] tc_value,
  output logic             at_tc
);

  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_tc = (count == tc_value);

endmodule
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder
// Description : Turns a debounced, synchronous button level into registered
//               single-cycle strobes (press, release, click, long, repeat)
//               and a held level.
//   clk_in      in   system clock, rising edge
//   rst_n_in    in   asynchronous active-low reset
//   level_in    in   debounced button level (1 = pressed)
//   press_out   out  strobe on press
//   release_out out  strobe on release
//   click_out   out  strobe on release before the long threshold
//   long_out    out  strobe when hold reaches LONG_CYCLES
//   repeat_out  out  strobe every REPEAT_CYCLES after a long press
//   held_out    out  level, high while pressed
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic level_in,
  output logic press_out,
  output logic release_out,
  output logic click_out,
  output logic long_out,
  output logic repeat_out,
  output logic held_out
);

  // The counter is cleared on the event edge and counts one per held edge,
  // so the threshold edge is the one where the count already equals N-1.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC =
    (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state_q, state_d;
  logic             press_d, release_d, click_d, long_d, repeat_d, held_d;
  logic             tmr_clear, tmr_inc, tmr_at_tc;
  logic [CNT_W-1:0] tmr_tc;

  interval_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .clear      (tmr_clear),
    .load       (1'b0),
    .load_value ('0),
    .inc        (tmr_inc),
    .tc_value   (tmr_tc),
    .at_tc      (tmr_at_tc)
  );

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    tmr_clear = 1'b0;
    tmr_inc   = 1'b0;
    tmr_tc    = '0;

    case (state_q)
      // A button held through reset must be seen released before arming.
      ARM: begin
        if (!level_in) state_d = IDLE;
      end

      IDLE: begin
        if (level_in) begin
          press_d   = 1'b1;
          tmr_clear = 1'b1;
          state_d   = PRESSED;
        end
      end

      PRESSED: begin
        tmr_tc = LONG_TC;
        // Release is checked first so it wins over the long threshold.
        if (!level_in) begin
          release_d = 1'b1;
          click_d   = 1'b1;
          state_d   = IDLE;
        end else if (tmr_at_tc) begin
          long_d    = 1'b1;
          tmr_clear = 1'b1;
          state_d   = LONG_HELD;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      LONG_HELD: begin
        tmr_tc = REPEAT_TC;
        if (!level_in) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (REPEAT_CYCLES != 0) begin
          if (tmr_at_tc) begin
            repeat_d  = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end

      default: begin
        state_d = ARM;
      end
    endcase

    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ARM;
      press_out   <= 1'b0;
      release_out <= 1'b0;
      click_out   <= 1'b0;
      long_out    <= 1'b0;
      repeat_out  <= 1'b0;
      held_out    <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_out   <= press_d;
      release_out <= release_d;
      click_out   <= click_d;
      long_out    <= long_d;
      repeat_out  <= repeat_d;
      held_out    <= held_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Self-checking bench for button_event_decoder. Two instances
//               share stimulus: one with auto-repeat (REPEAT=4) and one with
//               repeat disabled (REPEAT=0), both with LONG=8. Expected
//               strobes come from a timing model based on press edge times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R0 = 4;
  localparam int R1 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic level = 1'b0;

  logic p0, r0, c0, l0, q0, h0;
  logic p1, r1, c1, l1, q1, h1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  button_event_decoder #(.CNT_W(8), .LONG_CYCLES(L), .REPEAT_CYCLES(R0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .level_in(level),
    .press_out(p0), .release_out(r0), .click_out(c0),
    .long_out(l0), .repeat_out(q0), .held_out(h0)
  );

  button_event_decoder #(.CNT_W(8), .LONG_CYCLES(L), .REPEAT_CYCLES(R1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .level_in(level),
    .press_out(p1), .release_out(r1), .click_out(c1),
    .long_out(l1), .repeat_out(q1), .held_out(h1)
  );

  // Packed observation vectors: {press, release, click, long, repeat, held}
  logic [5:0] obs [2];
  assign obs[0] = {p0, r0, c0, l0, q0, h0};
  assign obs[1] = {p1, r1, c1, l1, q1, h1};

  // ---------------- reference model ----------------
  // Events are derived from how many edges have elapsed since the press edge.
  int         rep_period [2] = '{R0, R1};
  bit         armed      [2];
  bit         pressed    [2];
  int         press_edge [2];
  int         cyc = 0;
  logic [5:0] exp_v      [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      armed[i]   = 1'b0;
      pressed[i] = 1'b0;
      exp_v[i]   = 6'b0;
    end
  endtask

  task automatic model_edge(input int i, input logic lvl);
    int d;
    logic pr, rl, ck, lg, rp;
    pr = 0; rl = 0; ck = 0; lg = 0; rp = 0;
    if (!armed[i]) begin
      if (!lvl) armed[i] = 1'b1;
    end else if (!pressed[i]) begin
      if (lvl) begin
        pressed[i]    = 1'b1;
        press_edge[i] = cyc;
        pr            = 1'b1;
      end
    end else begin
      d = cyc - press_edge[i];
      if (!lvl) begin
        pressed[i] = 1'b0;
        rl         = 1'b1;
        ck         = (d <= L);
      end else if (d == L) begin
        lg = 1'b1;
      end else if (rep_period[i] != 0 && d > L && ((d - L) % rep_period[i]) == 0) begin
        rp = 1'b1;
      end
    end
    exp_v[i] = {pr, rl, ck, lg, rp, pressed[i]};
  endtask

  // One clock: drive level at negedge, advance the model at posedge,
  // then wait 1 time unit so outputs are sampled away from the edge.
  task automatic step(input logic lvl);
    @(negedge clk);
    level = lvl;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) model_edge(i, lvl);
    end else begin
      model_reset();
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    level = 1'($urandom_range(0, 1));
    model_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 6'b0) begin
        fails++;
        $display("FAIL reset inst%0d: got %b want %b", i, obs[i], 6'b0);
      end
    end
    step(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step(1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL reset_arm inst%0d: got %b want %b", i, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_short_press();
    logic lv [8] = '{1, 1, 1, 0, 0, 0, 1, 0};
    for (int n = 0; n < 8; n++) begin
      step(lv[n]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL short_press inst%0d cyc%0d: got %b want %b", i, n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_long_repeat();
    int nlong [2];
    int nrep  [2];
    int nclk  [2];
    for (int i = 0; i < 2; i++) begin nlong[i] = 0; nrep[i] = 0; nclk[i] = 0; end
    for (int n = 0; n < 23; n++) begin
      step(n < 20);
      for (int i = 0; i < 2; i++) begin
        nlong[i] += int'(obs[i][2]);
        nrep[i]  += int'(obs[i][1]);
        nclk[i]  += int'(obs[i][3]);
        checks++;
        if (obs[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL long_repeat inst%0d cyc%0d: got %b want %b", i, n, obs[i], exp_v[i]);
        end
      end
    end
    checks++;
    if (nrep[0] !== 2 || nrep[1] !== 0) begin
      fails++;
      $display("FAIL repeat_count: got %0d/%0d want 2/0", nrep[0], nrep[1]);
    end
    checks++;
    if (nlong[0] !== 1 || nlong[1] !== 1 || nclk[0] !== 0 || nclk[1] !== 0) begin
      fails++;
      $display("FAIL long_count: long %0d/%0d click %0d/%0d want 1/1 0/0",
               nlong[0], nlong[1], nclk[0], nclk[1]);
    end
  endtask

  // Hold for exactly L samples (release on the threshold edge), then L+1.
  task automatic test_boundary();
    for (int hold = L; hold <= L + 1; hold++) begin
      for (int n = 0; n < hold + 3; n++) begin
        step(n < hold);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (obs[i] !== exp_v[i]) begin
            fails++;
            $display("FAIL boundary_h%0d inst%0d cyc%0d: got %b want %b", hold, i, n, obs[i], exp_v[i]);
          end
        end
      end
    end
  endtask

  task automatic test_min_pulse();
    for (int n = 0; n < 4; n++) begin
      step(n == 0 || n == 2);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL min_pulse inst%0d cyc%0d: got %b want %b", i, n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_held_through_reset();
    @(negedge clk);
    rst_n = 1'b0;
    level = 1'b1;
    model_reset();
    step(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step(n < 5 || n >= 7);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL held_reset inst%0d cyc%0d: got %b want %b", i, n, obs[i], exp_v[i]);
        end
      end
    end
    step(1'b0);
    step(1'b0);
  endtask

  task automatic test_reset_mid_hold();
    for (int n = 0; n < 13; n++) step(1'b1);
    // Both instances are now in the long-held phase; reset between edges.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 6'b0) begin
        fails++;
        $display("FAIL reset_mid_hold inst%0d: got %b want %b", i, obs[i], 6'b0);
      end
    end
    step(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step(1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL after_reset inst%0d cyc%0d: got %b want %b", i, n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic lv;
    int   run;
    lv = 1'b0;
    for (int b = 0; b < 40; b++) begin
      lv  = ~lv;
      run = (lv) ? int'($urandom_range(1, 26)) : int'($urandom_range(1, 4));
      for (int n = 0; n < run; n++) begin
        step(lv);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (obs[i] !== exp_v[i]) begin
            fails++;
            $display("FAIL random inst%0d blk%0d: got %b want %b", i, b, obs[i], exp_v[i]);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_press();
    test_long_repeat();
    test_boundary();
    test_min_pulse();
    test_held_through_reset();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the debounced, clock-synchronous button level produced by the front-end debouncer and converts it into single-cycle event strobes for control logic: press, release, short click, long press and auto-repeat. It also exposes a held-state level. It sits between the debouncer output and any FSM or register block that reacts to user buttons.

## Interface
- CNT_W, 24: width of the internal interval counter.
- LONG_CYCLES, 1_000_000: hold duration in clocks before `long_out` fires. Legal range is 2 .. 2**CNT_W-1.
- REPEAT_CYCLES, 250_000: auto-repeat period in clocks after a long press. 0 disables repeat; otherwise ≤ 2**CNT_W-1.
- clk_in  input  1  single system clock; all logic is on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset; deassertion is synchronous to clk_in upstream.
- level_in  input  1  debounced button level (1 = pressed), already synchronous to clk_in.
- press_out  output  1  one-cycle strobe on press.
- release_out  output  1  one-cycle strobe on release.
- click_out  output  1  one-cycle strobe on a release that occurs before the long threshold.
- long_out  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.
- repeat_out  output  1  one-cycle strobe every REPEAT_CYCLES while the button remains held after a long press.
- held_out  output  1  level, high while the block considers the button pressed.

## Operation
- States:
  - ARM: the reset state.
  - IDLE
  - PRESSED
  - LONG_HELD
- ARM: the block waits for level_in=0 before arming, then moves to IDLE. A button held through reset generates no events until it is released and pressed again.
- IDLE, level_in=1: assert press_out, clear the counter, go to PRESSED.
- PRESSED, level_in=0: assert release_out and click_out, go to IDLE.
- PRESSED, level_in=1: count up. When the hold reaches LONG_CYCLES, assert long_out, clear the counter, go to LONG_HELD.
- LONG_HELD, level_in=0: assert release_out only (no click_out), go to IDLE.
- LONG_HELD, level_in=1, REPEAT_CYCLES≠0: assert repeat_out each time the counter reaches REPEAT_CYCLES, then restart the count.
- LONG_HELD, level_in=1, REPEAT_CYCLES=0: the counter holds and no repeats are issued.
- held_out = 1 in PRESSED and LONG_HELD; 0 in ARM and IDLE.
- Counter never wraps; it saturates at 2**CNT_W-1.
- Simultaneous events: if release is sampled on the same edge as the long threshold, release wins. The block asserts release_out and click_out; long_out is not asserted.
- Simultaneous events: if release coincides with a repeat threshold, release wins and repeat_out is not asserted.
- Strobes are mutually exclusive except for the release_out+click_out pair.
- Reset mid-operation: all outputs drop to 0 asynchronously and the state returns to ARM. No release_out is emitted for the interrupted press.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Press: level_in first sampled 1 at edge k (in IDLE) → press_out high for the cycle after edge k; held_out rises at the same time.
- Long: long_out is high exactly LONG_CYCLES cycles after the press_out cycle.
- Repeat: the n-th repeat_out (n≥1) is high n·REPEAT_CYCLES cycles after the long_out cycle.
- Release: level_in first sampled 0 at edge m → release_out (plus click_out if applicable) high for the cycle after edge m; held_out falls at the same time.
- Minimum press-to-press spacing is 2 cycles: a one-cycle high pulse on level_in yields press_out, then release_out+click_out on the next cycle.
- Throughput: one event per clock. There is no back-pressure; consumers must accept the strobes.

## Structure
- Shared package button_pkg:
  - `btn_state_t` enum: ARM, IDLE, PRESSED, LONG_HELD.
  - Default parameter constants, shared with the debouncer's instantiation wrapper.
- One natural sub-module, `interval_timer`: a loadable, saturating up-counter with clear and terminal-count compare, instantiated once. The FSM, edge logic and output registers stay in the top.

## Test plan
All scenarios use LONG_CYCLES=8 and REPEAT_CYCLES=4.
- Short press: level_in high for 3 cycles, then low → one press_out, then one release_out+click_out 3 cycles later; no long_out.
- Long press with repeat: hold for 20 cycles → press_out; long_out 8 cycles later; repeat_out at +4 and +8 after long_out; release_out with no click_out.
- Boundary: release sampled on the long-threshold edge → release_out+click_out, no long_out. Holding one cycle longer gives long_out, then release_out without click_out.
- Held through reset: level_in=1 while rst_n_in deasserts → no outputs. After level_in goes 0 and then 1, press_out fires normally.
- Reset mid-hold: assert rst_n_in low during LONG_HELD → all outputs 0 immediately, no release_out. Repeat the run with REPEAT_CYCLES=0 → long_out fires and no repeat_out follows.
